// File: rtl/tdm_demux8.sv
// 8-channel TDM receive demultiplexer: frame-sync driven hunt/lock alignment,
// per-channel registered sample outputs with one-cycle capture strobes.
module tdm_demux8 #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [8*WIDTH-1:0] dout,
  output logic [7:0]         ch_valid,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err,
  output logic [2:0]         slot
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state;
  logic [3:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      miss_cnt   <= '0;
      dout       <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      slot       <= '0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        unique case (state)
          HUNT: begin
            if (frame_sync) begin
              dout[WIDTH-1:0] <= din;
              ch_valid        <= 8'h01;
              slot            <= 3'd1;
              miss_cnt        <= '0;
              state           <= LOCKED;
              locked          <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // Sync anywhere realigns to slot 0; off-slot sync is flagged.
              dout[WIDTH-1:0] <= din;
              ch_valid        <= 8'h01;
              slot            <= 3'd1;
              miss_cnt        <= '0;
              sync_err        <= (slot != 3'd0);
            end else if (slot != 3'd0) begin
              for (int unsigned k = 1; k < 8; k++) begin
                if (3'(k) == slot) begin
                  dout[k*WIDTH +: WIDTH] <= din;
                  ch_valid[k]            <= 1'b1;
                end
              end
              frame_done <= (slot == 3'd7);
              slot       <= slot + 3'd1;
            end else begin
              sync_err <= 1'b1;
              if (miss_cnt + 4'd1 == 4'(MISS_LIMIT)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                slot     <= '0;
                miss_cnt <= '0;
              end else begin
                // Flywheel: trust the slot count for this frame.
                dout[WIDTH-1:0] <= din;
                ch_valid        <= 8'h01;
                slot            <= 3'd1;
                miss_cnt        <= miss_cnt + 4'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
